mkgauss_poly_ctrl: RTL and testbench

- Sequences one Gaussian sampler instance to fill a small polynomial (f or g) of N = 2^LOGN coefficients for key generation.
- Per coefficient: starts the sampler, forwards 64-bit PRNG words to it, then range-checks the result; on the final coefficient it also enforces odd parity of the coefficient sum.
- Accepted coefficients are written to an external coefficient RAM.
- Sits between the SHAKE-based PRNG and the sampler/coefficient-RAM datapath.

---
 rtl/falcon_keygen_pkg.sv | 29 ++
 rtl/mkgauss_accept_chk.sv | 27 ++
 rtl/mkgauss_poly_ctrl.sv | 133 +++++++++++++
 tb/tb_mkgauss_poly_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/falcon_keygen_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | falcon_keygen_pkg : shared types and constants for Falcon key generation
// | Revision: 1.0
// +-----------------------------------------------------------------------------
package falcon_keygen_pkg;

    localparam int c_COEF_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_FEED  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_t;

    // Largest coefficient bit size of f/g for a given log2 degree.
    function automatic int max_fg_bits(input int logn);
        case (logn)
            1, 2, 3, 4, 5: return 8;
            6, 7:          return 7;
            8, 9:          return 6;
            default:       return 5;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mkgauss_accept_chk.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | mkgauss_accept_chk : range and final-parity acceptance of one sampler result
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module mkgauss_accept_chk #(
    parameter int FG_BITS = 6
) (
    input  logic signed [31:0] s,
    input  logic               idx_is_last,
    input  logic               parity,
    output logic               accept,
    output logic               new_parity
);

    localparam int c_LIM = 1 << (FG_BITS - 1);

    logic w_in_range;
    logic w_parity_bad;

    assign w_in_range   = (s >= -c_LIM) && (s < c_LIM);
    assign new_parity   = parity ^ s[0];
    assign w_parity_bad = idx_is_last && !new_parity;
    assign accept       = w_in_range && !w_parity_bad;

endmodule
`default_nettype wire

// File: rtl/mkgauss_poly_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | mkgauss_poly_ctrl : drives one Gaussian sampler to fill an N-coefficient
// | polynomial; optional rejection counter under MKGAUSS_CTRL_STATS_EN.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module mkgauss_poly_ctrl
    import falcon_keygen_pkg::*;
#(
    parameter int LOGN    = 9,
    parameter int COEF_W  = c_COEF_W,
    parameter int FG_BITS = max_fg_bits(LOGN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              prng_valid,
    input  logic [63:0]       prng_data,
    output logic              prng_ready,
    output logic              gs_start,
    output logic              gs_rng_valid,
    output logic [63:0]       gs_rng,
    input  logic              gs_done,
    input  logic [31:0]       gs_val,
`ifdef MKGAUSS_CTRL_STATS_EN
    output logic [15:0]       rej_cnt,
`endif
    output logic              coef_we,
    output logic [LOGN-1:0]   coef_addr,
    output logic [COEF_W-1:0] coef_data
);

    ctrl_state_t        r_state;
    ctrl_state_t        w_next_state;
    logic [LOGN-1:0]    r_idx;
    logic               r_parity;
    logic signed [31:0] r_s;
    logic               w_idx_is_last;
    logic               w_accept;
    logic               w_new_parity;

    assign w_idx_is_last = (r_idx == {LOGN{1'b1}});

    mkgauss_accept_chk #(
        .FG_BITS(FG_BITS)
    ) u_accept_chk (
        .s          (r_s),
        .idx_is_last(w_idx_is_last),
        .parity     (r_parity),
        .accept     (w_accept),
        .new_parity (w_new_parity)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_parity <= 1'b0;
            r_s      <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_idx    <= '0;
                    r_parity <= 1'b0;
                end
                ST_FEED: if (gs_done) r_s <= $signed(gs_val);
                ST_CHECK: if (w_accept) begin
                    r_parity <= w_new_parity;
                    if (!w_idx_is_last) r_idx <= r_idx + LOGN'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        prng_ready   = 1'b0;
        gs_start     = 1'b0;
        coef_we      = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_ISSUE;
            ST_ISSUE: begin
                busy         = 1'b1;
                gs_start     = 1'b1;
                w_next_state = ST_FEED;
            end
            ST_FEED: begin
                busy       = 1'b1;
                prng_ready = 1'b1;
                if (gs_done) w_next_state = ST_CHECK;
            end
            ST_CHECK: begin
                busy         = 1'b1;
                coef_we      = w_accept;
                w_next_state = (w_accept && w_idx_is_last) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign gs_rng_valid = prng_valid & prng_ready;
    assign gs_rng       = prng_data;
    assign coef_addr    = r_idx;
    assign coef_data    = r_s[COEF_W-1:0];

`ifdef MKGAUSS_CTRL_STATS_EN
    logic [15:0] r_rej_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rej_cnt <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_rej_cnt <= '0;
        end else if (r_state == ST_CHECK && !w_accept && r_rej_cnt != 16'hFFFF) begin
            r_rej_cnt <= r_rej_cnt + 16'd1;
        end
    end

    assign rej_cnt = r_rej_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mkgauss_poly_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_mkgauss_poly_ctrl : randomized bench with a sampler stub and a
// | polynomial-level reference model.  Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_mkgauss_poly_ctrl;

    localparam int LOGN = 9;
    localparam int N    = 1 << LOGN;
    localparam int LIM  = 32;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            prng_valid = 1'b0;
    logic [63:0]     prng_data = '0;
    logic            gs_done = 1'b0;
    logic [31:0]     gs_val = '0;
    logic            busy, done, prng_ready, gs_start, gs_rng_valid, coef_we;
    logic [63:0]     gs_rng;
    logic [LOGN-1:0] coef_addr;
    logic [7:0]      coef_data;
`ifdef MKGAUSS_CTRL_STATS_EN
    logic [15:0]     rej_cnt;
`endif

    mkgauss_poly_ctrl #(.LOGN(LOGN)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .prng_valid  (prng_valid),
        .prng_data   (prng_data),
        .prng_ready  (prng_ready),
        .gs_start    (gs_start),
        .gs_rng_valid(gs_rng_valid),
        .gs_rng      (gs_rng),
        .gs_done     (gs_done),
        .gs_val      (gs_val),
`ifdef MKGAUSS_CTRL_STATS_EN
        .rej_cnt     (rej_cnt),
`endif
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a polynomial is complete when N values in range are
    // kept and the sum of all kept values is odd.
    int  vals[$];
    wr_t exp_q[$];
    int  exp_rej, m_idx, m_sum;
    bit  m_fin;

    task automatic model_reset();
        vals.delete();
        exp_q.delete();
        exp_rej = 0;
        m_idx   = 0;
        m_sum   = 0;
        m_fin   = 0;
    endtask

    task automatic model_push(input int v);
        vals.push_back(v);
        if (v < -LIM || v >= LIM) exp_rej++;
        else if (m_idx == N - 1 && ((m_sum + v) & 1) == 0) exp_rej++;
        else begin
            exp_q.push_back('{m_idx, v & 8'hFF});
            m_sum += v;
            if (m_idx == N - 1) m_fin = 1;
            else m_idx++;
        end
    endtask

    function automatic int rand_val();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 8) return int'($urandom_range(0, 63)) - 32;
        else if (r == 8) return 32 + int'($urandom_range(0, 300));
        else return -33 - int'($urandom_range(0, 300));
    endfunction

    task automatic gen_random();
        model_reset();
        while (!m_fin) model_push(rand_val());
    endtask

    task automatic gen_all_ones();
        model_reset();
        for (int i = 0; i < N + 2; i++) model_push(1);
        model_push(2);
    endtask

    task automatic gen_mixed();
        model_reset();
        model_push(-32);
        model_push(32);
        model_push(31);
        for (int i = 2; i < N - 1; i++) model_push(1);
        model_push(40);
        model_push(100);
        model_push(2);
        model_push(1);
    endtask

    // Sampler stub, PRNG source and write/done monitor, all at the falling edge.
    int  st = 0;
    int  need, got, writes_seen, since_write, done_cnt = 0;
    int  fixed_need = 0;
    bit  toggle_mode = 0, stray_en = 0, exp_ready;
    wr_t wr;

    always @(negedge clk) begin
        if (rst) begin
            st      = 0;
            gs_done = 1'b0;
            got     = 0;
        end else begin
            exp_ready = (st == 1 || st == 2);
            check("prng_ready", prng_ready, exp_ready);
            check("gs_rng_valid", gs_rng_valid, prng_valid & exp_ready);
            if (gs_rng_valid) check("gs_rng", gs_rng, prng_data);
            if (gs_start) check("gs_start_timing", (st == 0 || st == 4), 1);
            since_write++;
            if (coef_we) begin
                check("we_in_check", (st == 3), 1);
                if (exp_q.size() == 0) check("extra_write", 1, 0);
                else begin
                    wr = exp_q.pop_front();
                    check("coef_addr", coef_addr, wr.addr);
                    check("coef_data", coef_data, wr.data);
                end
                writes_seen++;
                since_write = 0;
            end
            if (done) begin
                done_cnt++;
                check("done_after_write", since_write, 1);
                check("writes_total", writes_seen, N);
                check("exp_left", exp_q.size(), 0);
`ifdef MKGAUSS_CTRL_STATS_EN
                check("rej_cnt_done", rej_cnt, exp_rej);
`endif
            end
            if (st == 3 || st == 4) begin
                gs_done = 1'b0;
                st      = 0;
            end
            if (st == 0 && gs_start) begin
                st   = 1;
                got  = 0;
                need = (fixed_need > 0) ? fixed_need : int'($urandom_range(1, 4));
            end else if (st == 1 || st == 2) begin
                if (got >= need) begin
                    gs_done = 1'b1;
                    if (vals.size() == 0) begin
                        check("stub_underflow", 1, 0);
                        gs_val = '0;
                    end else gs_val = vals.pop_front();
                    st = 3;
                end else begin
                    if (gs_rng_valid) got++;
                    st = 2;
                end
            end else if (st == 0 && stray_en && $urandom_range(0, 7) == 0) begin
                gs_done = 1'b1;
                gs_val  = $urandom_range(0, 20);
                st      = 4;
            end
            prng_valid = toggle_mode ? ~prng_valid : ($urandom_range(0, 9) < 7);
            prng_data  = {$urandom, $urandom};
        end
    end

    task automatic run_poly(input int busy_start_at);
        int  base;
        bit  injected;
        base        = done_cnt;
        writes_seen = 0;
        injected    = 0;
        start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
        check("busy_after_start", busy, 1);
`ifdef MKGAUSS_CTRL_STATS_EN
        check("rej_cnt_cleared", rej_cnt, 0);
`endif
        for (int c = 0; c < 20000 && done_cnt == base; c++) begin
            if (busy_start_at >= 0 && !injected && writes_seen == busy_start_at) begin
                start    = 1'b1;
                injected = 1;
                @(negedge clk); #2;
                start = 1'b0;
            end
            @(negedge clk); #2;
        end
        check("done_seen", done_cnt - base, 1);
        repeat (6) @(negedge clk);
        #2;
        check("single_done", done_cnt - base, 1);
        check("idle_busy", busy, 0);
        check("vals_left", vals.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_coef_we", coef_we, 0);
        check("rst_gs_start", gs_start, 0);
        check("rst_prng_ready", prng_ready, 0);
        check("rst_coef_addr", coef_addr, 0);
        check("rst_coef_data", coef_data, 0);
        rst = 1'b0;

        toggle_mode = 1;
        fixed_need  = 4;
        gen_all_ones();
        run_poly(-1);

        toggle_mode = 0;
        fixed_need  = 0;
        gen_mixed();
        run_poly(-1);

        stray_en = 1;
        gen_random();
        run_poly(-1);

        gen_random();
        run_poly(5);

        // Abort in the middle of a polynomial, then restart from address 0.
        gen_random();
        writes_seen = 0;
        start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
        for (int c = 0; c < 20000 && !(writes_seen == 100 && st == 2); c++) begin
            @(negedge clk); #2;
        end
        check("reached_idx100", writes_seen, 100);
        rst = 1'b1;
        @(negedge clk); #2;
        check("abort_busy", busy, 0);
        check("abort_coef_we", coef_we, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        gen_random();
        run_poly(-1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
